// File: rtl/pmem_responder.sv
// Line-granular pmem backing store: one 256-bit line read/write in flight, single-cycle pmem_resp.
// Latency: pmem_resp in the cycle after the LATENCY-th edge following acceptance; min period LATENCY+2.
// Backpressure: requester holds pmem_read/pmem_write until pmem_resp; an early drop aborts and flags proto_err.
module pmem_responder #(
    parameter int LINES   = 16,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         busy,
    output logic         proto_err
);

    localparam int         IDX_W    = $clog2(LINES);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic               op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [255:0]       mem_q [LINES];
    logic [255:0]       rdata_q;
    logic               perr_q;

    logic               req_any;
    logic               both_req;
    logic               req_held;
    logic               accept;
    logic               commit;
    logic               abort;
    logic [IDX_W-1:0]   req_idx;
    logic               unused_addr;

    assign req_any     = pmem_read | pmem_write;
    assign both_req    = pmem_read & pmem_write;
    // Only the request matching the captured op keeps the transaction alive.
    assign req_held    = op_q ? pmem_write : pmem_read;
    assign req_idx     = pmem_address[5 +: IDX_W];
    assign unused_addr = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_held) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= req_idx;
                // A simultaneous read+write is serviced as a read.
                op_q  <= pmem_write & ~pmem_read;
                cnt_q <= CNT_INIT;
                if (both_req) begin
                    perr_q <= 1'b1;
                end
            end else if (state_q == BUSY && req_held && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (abort) begin
                perr_q <= 1'b1;
            end
            if (commit && !op_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && op_q) begin
            mem_q[idx_q] <= pmem_wdata;
        end
    end

    assign pmem_resp  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign pmem_rdata = rdata_q;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized and directed bench for pmem_responder against an array-based memory model.
module tb_pmem_responder;

    localparam int LAT   = 4;
    localparam int NLINE = 16;

    logic         clk;
    logic         rst_n;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp, busy, proto_err;

    logic         read1, write1;
    logic [31:0]  addr1;
    logic [255:0] wdata1, rdata1;
    logic         resp1, busy1, perr1;

    int errors = 0;
    int checks = 0;

    logic [255:0] model_mem [NLINE];
    logic         model_perr;

    pmem_responder #(.LINES(NLINE), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy), .proto_err(proto_err)
    );

    pmem_responder #(.LINES(NLINE), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(read1), .pmem_write(write1),
        .pmem_address(addr1), .pmem_wdata(wdata1),
        .pmem_rdata(rdata1), .pmem_resp(resp1),
        .busy(busy1), .proto_err(perr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLINE; i++) model_mem[i] = '0;
        model_perr = 1'b0;
    endtask

    // Line index is address / 32 modulo the line count; read+write together counts as a read.
    task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [255:0] wd, output logic [255:0] exp_rd);
        int idx;
        idx = int'((a / 32) % NLINE);
        exp_rd = model_mem[idx];
        if (wr && !rd) model_mem[idx] = wd;
        if (rd && wr) model_perr = 1'b1;
    endtask

    // Drives one held request from a negedge with the DUT idle; reports what it saw.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] wd,
                          output int lat, output logic [255:0] rdat, output int bcnt,
                          output logic r_after, output logic b_after);
        pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
        lat = -1; rdat = '0; bcnt = 0;
        for (int e = 0; e < LAT + 8; e++) begin
            @(posedge clk); @(negedge clk);
            if (busy) bcnt++;
            if (pmem_resp) begin
                lat  = e;
                rdat = pmem_rdata;
                break;
            end
        end
        pmem_read = 1'b0; pmem_write = 1'b0;
        @(posedge clk); @(negedge clk);
        r_after = pmem_resp;
        b_after = busy;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
        read1 = 0; write1 = 0; addr1 = '0; wdata1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({pmem_resp, busy, proto_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: resp/busy/perr=%b expected 000", {pmem_resp, busy, proto_err});
        end
        checks++;
        if (pmem_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", pmem_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_resp, busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset_idle: resp/busy=%b expected 00", {pmem_resp, busy});
        end
    endtask

    task automatic test_first_read();
        int lat, bcnt; logic [255:0] rd, exp; logic ra, ba;
        model_apply(1, 0, 32'h0000_0040, '0, exp);
        do_txn(1, 0, 32'h0000_0040, '0, lat, rd, bcnt, ra, ba);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL first_read_latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL first_read_rdata: got %h expected %h", rd, exp); end
        checks++;
        if (bcnt !== LAT + 1) begin errors++; $display("FAIL first_read_busy_cycles: got %0d expected %0d", bcnt, LAT + 1); end
        checks++;
        if ({ra, ba} !== 2'b00) begin errors++; $display("FAIL first_read_one_pulse: resp/busy after=%b expected 00", {ra, ba}); end
    endtask

    task automatic test_write_read_alias();
        int lat, bcnt; logic [255:0] rd, exp; logic ra, ba;
        logic [31:0] addrs [3];
        addrs[0] = 32'h3F; addrs[1] = 32'h40; addrs[2] = 32'h220;
        model_apply(0, 1, 32'h20, {8{32'hDEADBEEF}}, exp);
        do_txn(0, 1, 32'h20, {8{32'hDEADBEEF}}, lat, rd, bcnt, ra, ba);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < 3; i++) begin
            model_apply(1, 0, addrs[i], '0, exp);
            do_txn(1, 0, addrs[i], '0, lat, rd, bcnt, ra, ba);
            checks++;
            if (rd !== exp || lat !== LAT) begin
                errors++;
                $display("FAIL read_addr_%h: got %h lat %0d expected %h lat %0d", addrs[i], rd, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses; int first_e, second_e;
        logic [255:0] exp;
        pulses = 0; first_e = -1; second_e = -1;
        model_apply(1, 0, 32'h20, '0, exp);
        pmem_read = 1'b1; pmem_address = 32'h20;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); @(negedge clk);
            if (pmem_resp) begin
                pulses++;
                if (first_e < 0) first_e = e; else second_e = e;
                checks++;
                if (pmem_rdata !== exp) begin errors++; $display("FAIL held_read_rdata: got %h expected %h", pmem_rdata, exp); end
            end
        end
        pmem_read = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL held_pulse_count: got %0d expected 2", pulses); end
        checks++;
        if (first_e !== LAT || second_e !== 2 * LAT + 2) begin
            errors++;
            $display("FAIL held_pulse_edges: got %0d,%0d expected %0d,%0d", first_e, second_e, LAT, 2 * LAT + 2);
        end
    endtask

    task automatic test_abort();
        int lat, bcnt, seen; logic [255:0] rd, exp; logic ra, ba;
        apply_reset();
        seen = 0;
        pmem_write = 1'b1; pmem_address = 32'h60; pmem_wdata = rand_line();
        repeat (2) begin @(posedge clk); @(negedge clk); if (pmem_resp) seen++; end
        pmem_write = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL abort_proto_err: got %b expected 1", proto_err); end
        model_perr = 1'b1;
        repeat (5) begin if (pmem_resp) seen++; @(posedge clk); @(negedge clk); end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", seen); end
        model_apply(1, 0, 32'h60, '0, exp);
        do_txn(1, 0, 32'h60, '0, lat, rd, bcnt, ra, ba);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL abort_no_commit: got %h expected %h", rd, exp); end
    endtask

    task automatic test_both_high();
        int lat, bcnt; logic [255:0] rd, exp, pat; logic ra, ba;
        apply_reset();
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_cleared_by_reset: got %b expected 0", proto_err); end
        pat = rand_line();
        model_apply(0, 1, 32'h40, pat, exp);
        do_txn(0, 1, 32'h40, pat, lat, rd, bcnt, ra, ba);
        model_apply(1, 1, 32'h40, 256'h1, exp);
        do_txn(1, 1, 32'h40, 256'h1, lat, rd, bcnt, ra, ba);
        checks++;
        if (rd !== exp || lat !== LAT) begin errors++; $display("FAIL both_high_read: got %h lat %0d expected %h lat %0d", rd, lat, exp, LAT); end
        checks++;
        if (proto_err !== model_perr) begin errors++; $display("FAIL both_high_perr: got %b expected %b", proto_err, model_perr); end
        model_apply(1, 0, 32'h40, '0, exp);
        do_txn(1, 0, 32'h40, '0, lat, rd, bcnt, ra, ba);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL both_high_line_unchanged: got %h expected %h", rd, exp); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, guard; logic [255:0] rd, exp; logic ra, ba;
        pmem_write = 1'b1; pmem_address = 32'hA0; pmem_wdata = rand_line();
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, pmem_resp} !== 2'b00) begin errors++; $display("FAIL reset_mid_busy: busy/resp=%b expected 00", {busy, pmem_resp}); end
        pmem_write = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        model_apply(1, 0, 32'hA0, '0, exp);
        do_txn(1, 0, 32'hA0, '0, lat, rd, bcnt, ra, ba);
        checks++;
        if (rd !== exp || lat !== LAT) begin errors++; $display("FAIL reset_mid_unwritten: got %h lat %0d expected %h lat %0d", rd, lat, exp, LAT); end
        pmem_read = 1'b1; pmem_address = 32'h0;
        guard = 0;
        while (!pmem_resp && guard < LAT + 8) begin @(posedge clk); @(negedge clk); guard++; end
        checks++;
        if (pmem_resp !== 1'b1) begin errors++; $display("FAIL reset_resp_reached: resp=%b expected 1", pmem_resp); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, pmem_resp} !== 2'b00) begin errors++; $display("FAIL reset_in_resp: busy/resp=%b expected 00", {busy, pmem_resp}); end
        pmem_read = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_latency1();
        logic [255:0] pat; int lat;
        pat = rand_line();
        for (int pass = 0; pass < 2; pass++) begin
            read1 = (pass == 1); write1 = (pass == 0); addr1 = 32'hE0; wdata1 = pat;
            lat = -1;
            for (int e = 0; e < 6; e++) begin
                @(posedge clk); @(negedge clk);
                if (resp1) begin lat = e; break; end
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL lat1_pass%0d_latency: got %0d expected 1", pass, lat); end
            if (pass == 1) begin
                checks++;
                if (rdata1 !== pat) begin errors++; $display("FAIL lat1_rdata: got %h expected %h", rdata1, pat); end
            end
            read1 = 1'b0; write1 = 1'b0;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, sel; logic [255:0] rd, exp, wd; logic ra, ba; logic [31:0] a; bit r, w;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            r = (sel == 0) || (sel >= 5);
            w = (sel <= 4);
            a = $urandom;
            wd = rand_line();
            model_apply(r, w, a, wd, exp);
            do_txn(r, w, a, wd, lat, rd, bcnt, ra, ba);
            checks++;
            if (lat !== LAT || ra !== 1'b0) begin errors++; $display("FAIL rand%0d_timing: lat %0d resp_after %b expected %0d 0", n, lat, ra, LAT); end
            if (r) begin
                checks++;
                if (rd !== exp) begin errors++; $display("FAIL rand%0d_rdata: got %h expected %h", n, rd, exp); end
            end
            checks++;
            if (proto_err !== model_perr) begin errors++; $display("FAIL rand%0d_perr: got %b expected %b", n, proto_err, model_perr); end
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read_alias();
        test_back_to_back();
        test_abort();
        test_both_high();
        test_reset_mid();
        test_latency1();
        apply_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
